// File: rtl/rotary_color_controller.sv
// rotary_color_controller
//   Rotary-encoder driven RGB colour editor feeding a WS2812B frame driver.
//   Three 8-bit channels (G, R, B) are stepped up/down with saturation on the
//   currently selected channel. Any real change, and a periodic refresh tick,
//   marks the colour dirty. A small scheduler then snapshots the colour and
//   offers it to the driver, followed by a latch hold before the next frame.
//
// Ports
//   clk          system clock (40 MHz), rising-edge
//   res          asynchronous active-high reset
//   rotation_up  single-cycle clockwise step pulse
//   rotation_dn  single-cycle counter-clockwise step pulse
//   button       single-cycle debounced pulse, advances channel_sel
//   color_ready  driver ready to accept a frame
//   color_valid  frame offer to the driver
//   color_data   frame {G, R, B}
//   channel_sel  selected channel: 0=G, 1=R, 2=B
module rotary_color_controller #(
  parameter int unsigned STEP           = 8,
  parameter int unsigned LATCH_CYCLES   = 12000,
  parameter int unsigned REFRESH_CYCLES = 4000000
) (
  input  logic        clk,
  input  logic        res,
  input  logic        rotation_up,
  input  logic        rotation_dn,
  input  logic        button,
  input  logic        color_ready,
  output logic        color_valid,
  output logic [23:0] color_data,
  output logic [1:0]  channel_sel
);

  localparam int unsigned LW = (LATCH_CYCLES   > 1) ? $clog2(LATCH_CYCLES)   : 1;
  localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [LW-1:0] LATCH_LAST   = LW'(LATCH_CYCLES - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [8:0]    STEP9        = 9'(STEP);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    HOLD
  } state_e;

  state_e         state_q, state_d;
  logic [7:0]     g_q, g_d;
  logic [7:0]     r_q, r_d;
  logic [7:0]     b_q, b_d;
  logic [1:0]     sel_q, sel_d;
  logic           dirty_q, dirty_d;
  logic [23:0]    data_q, data_d;
  logic [LW-1:0]  latch_q, latch_d;
  logic [RW-1:0]  refresh_q, refresh_d;

  logic [7:0]     cur_val;
  logic [8:0]     sum9;
  logic [8:0]     diff9;
  logic [7:0]     new_val;
  logic           step_en;
  logic           changed;
  logic           refresh_hit;
  logic           capture;

  // Channel stepping: 9-bit arithmetic, then saturate to 0..255.
  always_comb begin
    g_d     = g_q;
    r_d     = r_q;
    b_d     = b_q;
    cur_val = g_q;
    case (sel_q)
      2'd1:    cur_val = r_q;
      2'd2:    cur_val = b_q;
      default: cur_val = g_q;
    endcase

    sum9    = {1'b0, cur_val} + STEP9;
    diff9   = {1'b0, cur_val} - STEP9;
    step_en = rotation_up ^ rotation_dn;

    if (rotation_up) begin
      new_val = sum9[8] ? 8'hFF : sum9[7:0];
    end else begin
      // A borrow out of the 9-bit subtract means the result went negative.
      new_val = diff9[8] ? 8'h00 : diff9[7:0];
    end

    changed = step_en && (new_val != cur_val);

    // The write uses the pre-advance selection, so a coincident button
    // press steps the old channel.
    if (changed) begin
      case (sel_q)
        2'd1:    r_d = new_val;
        2'd2:    b_d = new_val;
        default: g_d = new_val;
      endcase
    end
  end

  always_comb begin
    sel_d = sel_q;
    if (button) begin
      case (sel_q)
        2'd0:    sel_d = 2'd1;
        2'd1:    sel_d = 2'd2;
        default: sel_d = 2'd0;
      endcase
    end
  end

  // Free-running refresh counter, independent of the scheduler state.
  always_comb begin
    refresh_hit = (refresh_q == REFRESH_LAST);
    refresh_d   = refresh_hit ? '0 : refresh_q + RW'(1);
  end

  // Scheduler: snapshot in IDLE, offer in SEND, latch hold in HOLD.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    latch_d = latch_q;
    capture = 1'b0;

    case (state_q)
      IDLE: begin
        if (dirty_q) begin
          capture = 1'b1;
          data_d  = {g_q, r_q, b_q};
          state_d = SEND;
        end
      end
      SEND: begin
        if (color_ready) begin
          state_d = HOLD;
          latch_d = '0;
        end
      end
      HOLD: begin
        if (latch_q == LATCH_LAST) begin
          state_d = IDLE;
        end else begin
          latch_d = latch_q + LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Set wins over clear: a change in the capture cycle is not in the
    // snapshot, so it must schedule another frame.
    if (changed || refresh_hit) begin
      dirty_d = 1'b1;
    end else if (capture) begin
      dirty_d = 1'b0;
    end else begin
      dirty_d = dirty_q;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= IDLE;
      g_q       <= '0;
      r_q       <= '0;
      b_q       <= '0;
      sel_q     <= '0;
      dirty_q   <= 1'b1;
      data_q    <= '0;
      latch_q   <= '0;
      refresh_q <= '0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      r_q       <= r_d;
      b_q       <= b_d;
      sel_q     <= sel_d;
      dirty_q   <= dirty_d;
      data_q    <= data_d;
      latch_q   <= latch_d;
      refresh_q <= refresh_d;
    end
  end

  assign color_valid = (state_q == SEND);
  assign color_data  = data_q;
  assign channel_sel = sel_q;

endmodule

// File: tb/tb_rotary_color_controller.sv
// Testbench for rotary_color_controller: scoreboard of expected frames,
// pushed when stimulus is driven and popped at each handshake.
module tb_rotary_color_controller;

  localparam int unsigned STEP    = 8;
  localparam int unsigned LATCH   = 16;
  localparam int unsigned REFRESH = 8000;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        rotation_up = 1'b0;
  logic        rotation_dn = 1'b0;
  logic        button = 1'b0;
  logic        color_ready = 1'b1;
  logic        color_valid;
  logic [23:0] color_data;
  logic [1:0]  channel_sel;

  rotary_color_controller #(
    .STEP(STEP),
    .LATCH_CYCLES(LATCH),
    .REFRESH_CYCLES(REFRESH)
  ) dut (
    .clk(clk),
    .res(res),
    .rotation_up(rotation_up),
    .rotation_dn(rotation_dn),
    .button(button),
    .color_ready(color_ready),
    .color_valid(color_valid),
    .color_data(color_data),
    .channel_sel(channel_sel)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned frames  = 0;
  logic [31:0] exp_q[$];

  // Reference colour state
  int g_m = 0;
  int r_m = 0;
  int b_m = 0;
  int sel_m = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] frame_of();
    return {8'h00, 8'(g_m), 8'(r_m), 8'(b_m)};
  endfunction

  function automatic int step_up(input int v);
    return (v + int'(STEP) > 255) ? 255 : v + int'(STEP);
  endfunction

  function automatic int step_dn(input int v);
    return (v < int'(STEP)) ? 0 : v - int'(STEP);
  endfunction

  // Handshake monitor: sampled on the falling edge, ahead of the rising
  // edge where the transfer takes place.
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [31:0] mon_exp;
  always @(negedge clk) begin
    if (res) begin
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (prev_v && !prev_r) check_eq("valid_held", 32'(color_valid), 32'd1);
      if (color_valid && color_ready) begin
        if (exp_q.size() != 0) mon_exp = exp_q.pop_front();
        else mon_exp = 32'hDEAD_BEEF;
        check_eq("frame", {8'h00, color_data}, mon_exp);
        frames++;
      end
      prev_v = color_valid;
      prev_r = color_ready;
    end
  end

  // Drive one single-cycle pulse starting now; returns one falling edge later.
  task automatic drive(input logic u, input logic d, input logic btn);
    int cur;
    int nv;
    cur = (sel_m == 0) ? g_m : (sel_m == 1) ? r_m : b_m;
    nv  = cur;
    if (u && !d) nv = step_up(cur);
    else if (d && !u) nv = step_dn(cur);
    case (sel_m)
      0:       g_m = nv;
      1:       r_m = nv;
      default: b_m = nv;
    endcase
    if (nv != cur) exp_q.push_back(frame_of());
    if (btn) sel_m = (sel_m == 2) ? 0 : sel_m + 1;
    rotation_up = u;
    rotation_dn = d;
    button      = btn;
    @(negedge clk);
    rotation_up = 1'b0;
    rotation_dn = 1'b0;
    button      = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
    check_eq({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    repeat (LATCH + 6) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          len;
    int          low;
    int          vcnt;
    int          dcnt;
    int unsigned f0;
    logic [23:0] d0;
    logic [31:0] exp033;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 32'(color_valid), 32'd0);
    check_eq("rst_data", {8'h00, color_data}, 32'd0);
    check_eq("rst_sel", 32'(channel_sel), 32'd0);
    exp_q.push_back(32'd0);
    @(posedge clk);
    #1 res = 1'b0;

    // First frame after reset is all-zero, one valid cycle, then the hold
    for (int i = 0; i < 20 && !color_valid; i++) @(negedge clk);
    check_eq("first_valid", 32'(color_valid), 32'd1);
    len = 0;
    while (color_valid && len < 50) begin
      len++;
      @(negedge clk);
    end
    check_eq("valid_len", 32'(len), 32'd1);
    low = 1;
    drive(1'b1, 1'b0, 1'b0);           // G: 0 -> 8, during HOLD
    while (!color_valid && low < 200) begin
      low++;
      @(negedge clk);
    end
    // HOLD cycles plus the single IDLE capture cycle
    check_eq("hold_gap", 32'(low), 32'(LATCH + 1));
    wait_quiet("hold", 100);

    // Button coincident with rotation_up on G
    drive(1'b1, 1'b0, 1'b1);           // G: 8 -> 16, sel -> 1
    check_eq("btn_sel", 32'(channel_sel), 32'(sel_m));
    wait_quiet("btn", 100);

    // Up and down together: ignored
    drive(1'b1, 1'b1, 1'b0);
    vcnt = 0;
    repeat (LATCH + 10) begin
      @(negedge clk);
      if (color_valid) vcnt++;
    end
    check_eq("both_novalid", 32'(vcnt), 32'd0);

    // R saturation: 40 spaced pulses, only 32 produce frames
    f0 = frames;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      repeat (29) @(negedge clk);
    end
    wait_quiet("rsat", 100);
    check_eq("rsat_frames", 32'(frames - f0), 32'd32);
    check_eq("rsat_model", 32'(r_m), 32'd255);

    // Select B, hold color_ready low
    drive(1'b0, 1'b0, 1'b1);
    check_eq("sel_b", 32'(channel_sel), 32'd2);
    @(posedge clk);
    #1 color_ready = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0);           // B at 0: saturated, no frame
    vcnt = 0;
    repeat (LATCH + 10) begin
      @(negedge clk);
      if (color_valid) vcnt++;
    end
    check_eq("dn_sat_novalid", 32'(vcnt), 32'd0);
    drive(1'b1, 1'b0, 1'b0);           // B: 0 -> 8
    exp033 = frame_of();
    for (int i = 0; i < 10 && !color_valid; i++) @(negedge clk);
    check_eq("stall_valid", 32'(color_valid), 32'd1);
    d0 = color_data;
    drive(1'b1, 1'b0, 1'b0);           // B: 8 -> 16 while stalled
    vcnt = 0;
    dcnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (color_valid) vcnt++;
      if (color_data != d0) dcnt++;
    end
    check_eq("stall_hold", 32'(vcnt), 32'd100);
    check_eq("stall_stable", 32'(dcnt), 32'd0);
    check_eq("stall_data", {8'h00, d0}, exp033);
    @(posedge clk);
    #1 color_ready = 1'b1;
    @(negedge clk);
    wait_quiet("stall", 200);

    // Reset asserted mid-HOLD
    drive(1'b0, 1'b1, 1'b0);           // B: 16 -> 8
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check_eq("pre_rst_drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 res = 1'b1;
    #2;
    check_eq("arst_valid", 32'(color_valid), 32'd0);
    check_eq("arst_data", {8'h00, color_data}, 32'd0);
    check_eq("arst_sel", 32'(channel_sel), 32'd0);
    g_m = 0;
    r_m = 0;
    b_m = 0;
    sel_m = 0;
    exp_q.push_back(frame_of());
    repeat (3) @(posedge clk);
    #1 res = 1'b0;
    @(negedge clk);
    wait_quiet("rst2", 100);

    // Periodic refresh resends the unchanged colour
    drive(1'b1, 1'b0, 1'b0);           // G: 0 -> 8
    wait_quiet("g_post", 100);
    exp_q.push_back(frame_of());
    wait_quiet("refresh", REFRESH + 200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
